// File: rtl/servo_pwm_if.sv
// Processor-side write/readback bus of the servo PWM peripheral.
// The master drives writes and read requests; the slave returns readback data.
interface servo_pwm_if;
  logic        wr_strobe;
  logic [4:0]  wr_sel;
  logic [31:0] d_in;
  logic        rd_req;
  logic [4:0]  rd_sel;
  logic [31:0] d_out;
  logic        rd_valid;

  modport master (
    output wr_strobe, wr_sel, d_in, rd_req, rd_sel,
    input  d_out, rd_valid
  );

  modport slave (
    input  wr_strobe, wr_sel, d_in, rd_req, rd_sel,
    output d_out, rd_valid
  );
endinterface

// File: rtl/servo_pwm_engine.sv
// Eight-channel servo PWM engine with frame-boundary double buffering and readback.
// Optional macro SERVO_FRAME_CNT_EN adds a 16-bit frame counter readable at index 24.
module servo_pwm_engine #(
  parameter int PERIOD_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  servo_pwm_if.slave bus,
  output logic [7:0] pwm,
  output logic [7:0] dir,
  output logic       frame_start
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    e_q   [8];
  logic [31:0]   t_q   [8];
  logic [1:0]    d_q   [8];
  logic [1:0]    act_e [8];
  logic [31:0]   act_t [8];
  logic [31:0]   rd_data;
  logic [31:0]   status;
  logic          load;

  assign load = (cnt == LAST);

`ifdef SERVO_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign status = {16'h0, frame_cnt};
`else
  assign status = '0;
`endif

  // Readback sees the pending registers before any same-cycle write lands.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rd_sel == 5'(3 * i))     rd_data = {30'b0, e_q[i]};
      if (bus.rd_sel == 5'(3 * i + 1)) rd_data = t_q[i];
      if (bus.rd_sel == 5'(3 * i + 2)) rd_data = {30'b0, d_q[i]};
    end
    if (bus.rd_sel == 5'd24) rd_data = status;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      pwm          <= '0;
      dir          <= '0;
      frame_start  <= 1'b0;
      bus.d_out    <= '0;
      bus.rd_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        e_q[i]   <= '0;
        t_q[i]   <= '0;
        d_q[i]   <= '0;
        act_e[i] <= '0;
        act_t[i] <= '0;
      end
    end else begin
      cnt         <= load ? '0 : cnt + CW'(1);
      frame_start <= (cnt == '0);
      for (int i = 0; i < 8; i++) begin
        // Bit 1 of the enable field flips the polarity of an enabled channel.
        pwm[i] <= act_e[i][0] & ((32'(cnt) < act_t[i]) ^ act_e[i][1]);
        dir[i] <= d_q[i][0];
        if (load) begin
          act_e[i] <= e_q[i];
          act_t[i] <= t_q[i];
        end
        if (bus.wr_strobe) begin
          if (bus.wr_sel == 5'(3 * i))     e_q[i] <= bus.d_in[1:0];
          if (bus.wr_sel == 5'(3 * i + 1)) t_q[i] <= bus.d_in;
          if (bus.wr_sel == 5'(3 * i + 2)) d_q[i] <= bus.d_in[1:0];
        end
      end
      bus.rd_valid <= bus.rd_req;
      if (bus.rd_req) bus.d_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_servo_pwm_engine.sv
// Bench for servo_pwm_engine: directed steps plus random traffic against a frame-level model.
// Every cycle the outputs are compared with the model's prediction.
module tb_servo_pwm_engine;
  localparam int P = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pwm;
  logic [7:0] dir;
  logic       frame_start;

  always #5 clk = ~clk;

  servo_pwm_if bus ();

  servo_pwm_engine #(.PERIOD_CYCLES(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .pwm         (pwm),
    .dir         (dir),
    .frame_start (frame_start)
  );

  int tests_run = 0;
  int failed    = 0;

  // Model: pending and active settings, plus edges elapsed since reset release.
  logic [1:0]  m_e [8];
  logic [31:0] m_t [8];
  logic [1:0]  m_d [8];
  logic [1:0]  a_e [8];
  logic [31:0] a_t [8];
  int          n;
  logic [7:0]  exp_pwm;
  logic [7:0]  exp_dir;
  logic        exp_fs;
  logic        exp_rv;
  logic [31:0] exp_dout;

  function automatic logic level(int ch, int pos);
    longint w = longint'(a_t[ch]);
    if (w > P) w = P;
    return a_e[ch][0] & ((pos < w) ^ a_e[ch][1]);
  endfunction

  function automatic logic [31:0] model_read(int sel, int edges);
    int ch = sel / 3;
    if (sel < 24) begin
      case (sel % 3)
        0:       return {30'b0, m_e[ch]};
        1:       return m_t[ch];
        default: return {30'b0, m_d[ch]};
      endcase
    end
    if (sel == 24) begin
`ifdef SERVO_FRAME_CNT_EN
      // Frame starts follow edges 0, P, 2P...; the counter bumps one edge later.
      int frames = (edges >= 2) ? ((edges - 2) / P + 1) : 0;
      return {16'h0, 16'(frames % 65536)};
`else
      return 32'(edges * 0);
`endif
    end
    return '0;
  endfunction

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] expv);
    tests_run++;
    assert (obs === expv)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    int pos;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        m_e[i] = '0; m_t[i] = '0; m_d[i] = '0; a_e[i] = '0; a_t[i] = '0;
      end
      n = 0; exp_pwm = '0; exp_dir = '0; exp_fs = 1'b0; exp_rv = 1'b0; exp_dout = '0;
    end else begin
      pos = n % P;
      for (int i = 0; i < 8; i++) begin
        exp_pwm[i] = level(i, pos);
        exp_dir[i] = m_d[i][0];
      end
      exp_fs = (pos == 0);
      exp_rv = bus.rd_req;
      if (bus.rd_req) exp_dout = model_read(int'(bus.rd_sel), n);
      if (pos == P - 1) begin
        for (int i = 0; i < 8; i++) begin
          a_e[i] = m_e[i];
          a_t[i] = m_t[i];
        end
      end
      if (bus.wr_strobe && bus.wr_sel < 5'd24) begin
        case (int'(bus.wr_sel) % 3)
          0:       m_e[int'(bus.wr_sel) / 3] = bus.d_in[1:0];
          1:       m_t[int'(bus.wr_sel) / 3] = bus.d_in;
          default: m_d[int'(bus.wr_sel) / 3] = bus.d_in[1:0];
        endcase
      end
      n++;
    end
    @(negedge clk);
    check_output("pwm", 32'(pwm), 32'(exp_pwm));
    check_output("dir", 32'(dir), 32'(exp_dir));
    check_output("frame_start", 32'(frame_start), 32'(exp_fs));
    check_output("rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
    check_output("d_out", bus.d_out, exp_dout);
  endtask

  task automatic run_cycles(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic apply_stimulus(logic [4:0] sel, logic [31:0] data);
    bus.wr_strobe = 1'b1;
    bus.wr_sel    = sel;
    bus.d_in      = data;
    tick();
    bus.wr_strobe = 1'b0;
  endtask

  task automatic read_reg(logic [4:0] sel);
    bus.rd_req = 1'b1;
    bus.rd_sel = sel;
    tick();
    bus.rd_req = 1'b0;
  endtask

  // Stop so that the next edge sees the requested frame position.
  task automatic wait_pos(int p);
    for (int i = 0; i <= P && (n % P) != p; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.wr_strobe = 1'b0; bus.wr_sel = '0; bus.d_in = '0;
    bus.rd_req = 1'b0; bus.rd_sel = '0;

    // Reset held with writes active, then readback of every index.
    bus.wr_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_sel = 5'(i * 3 + 1);
      bus.d_in   = $urandom;
      tick();
    end
    bus.wr_strobe = 1'b0;
    rst = 1'b1;
    for (int s = 0; s < 25; s++) read_reg(5'(s));
    tick();

    // Basic pulse written mid-frame.
    wait_pos(40);
    apply_stimulus(5'd1, 32'd25);
    apply_stimulus(5'd0, 32'd1);
    run_cycles(2 * P);

    // Boundary widths and inverted polarity.
    apply_stimulus(5'd4, 32'd0);
    apply_stimulus(5'd3, 32'd1);
    apply_stimulus(5'd7, 32'd100);
    apply_stimulus(5'd6, 32'd1);
    apply_stimulus(5'd9, 32'd3);
    apply_stimulus(5'd10, 32'd10);
    run_cycles(2 * P);
    apply_stimulus(5'd7, 32'hFFFF_FFFF);
    run_cycles(2 * P);

    // Write landing on the load edge applies one frame late.
    wait_pos(P - 1);
    apply_stimulus(5'd1, 32'd50);
    run_cycles(2 * P + 10);

    // Direction, readback, collision, out-of-range index.
    apply_stimulus(5'd17, 32'h3);
    run_cycles(2);
    read_reg(5'd17);
    tick();
    bus.wr_strobe = 1'b1; bus.wr_sel = 5'd4; bus.d_in = 32'd77;
    bus.rd_req = 1'b1; bus.rd_sel = 5'd4;
    tick();
    bus.wr_strobe = 1'b0;
    bus.rd_req = 1'b0;
    read_reg(5'd4);
    read_reg(5'd30);
    read_reg(5'd1);
    read_reg(5'd24);
    tick();

    // Random traffic with a mid-frame reset pulse.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] ws;
      ws = 5'($urandom_range(0, 31));
      bus.wr_strobe = ($urandom_range(0, 3) == 0);
      bus.wr_sel    = ws;
      bus.d_in      = (int'(ws) % 3 == 1) ? 32'($urandom_range(0, 120)) : $urandom;
      bus.rd_req    = $urandom_range(0, 1) == 1;
      bus.rd_sel    = 5'($urandom_range(0, 31));
      rst           = !(c == 237);
      tick();
    end
    bus.wr_strobe = 1'b0;
    bus.rd_req = 1'b0;
    rst = 1'b1;
    run_cycles(5 * P + 3);
    read_reg(5'd24);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/servo_pwm_engine.md
# servo_pwm_engine

Read side of the 8-servo PWM peripheral. Holds the per-channel register file filled by the bus-side write demux: enable E, pulse width T and direction D for channels 0-7. Generates the eight servo PWM waveforms from double-buffered copies of E and T, so channels update glitch-free only at frame boundaries. Also provides a one-cycle-latency readback port for the processor.

## Interface
Parameters:
- PERIOD_CYCLES, 1000000, frame length in clk cycles (20 ms at 50 MHz); must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- wr_strobe  in  1  write enable, one cycle per write.
- wr_sel  in  5  register index; index = 3·ch + {0: E, 1: T, 2: D}; indices 0-23 are valid.
- d_in  in  32  write data.
- rd_req  in  1  readback request.
- rd_sel  in  5  readback register index; same map as wr_sel, plus 24 = status.
- d_out  out  32  readback data.
- rd_valid  out  1  one-cycle pulse marking d_out valid.
- pwm  out  8  servo PWM outputs, bit i = channel i.
- dir  out  8  direction outputs, bit i = D[i][0].
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
Pending registers:
- Widths: E[i] is 2 bits, T[i] is 32 bits, D[i] is 2 bits.
- Write: on wr_strobe with wr_sel ≤ 23, store d_in truncated to the register width.
- wr_sel ≥ 24: the write is ignored.

Frame counter:
- cnt counts 0 … PERIOD_CYCLES-1, then wraps to 0.
- Load cycle: the cycle where cnt == PERIOD_CYCLES-1.
- On the load edge, copy E[i] → act_E[i] and T[i] → act_T[i] for all channels.
- A write on the same edge as the load is not captured; it applies to the following frame.

PWM:
- pwm[i] <= act_E[i][0] & (cnt < act_T[i]), registered.
- act_E[i][1] = 1 inverts the channel's output polarity.
- act_T[i] = 0: output stays inactive.
- act_T[i] ≥ PERIOD_CYCLES: output stays active for the whole frame.

Direction:
- dir[i] <= D[i][0], registered.
- D is not double-buffered; it follows a write one cycle later.

Readback:
- rd_req in cycle n → d_out and rd_valid in cycle n+1.
- Data returned is the pending register, zero-extended to 32 bits.
- rd_sel > 24: returns 0.
- Read and write to the same index in the same cycle: the read returns the old value.
- d_out holds its last value when rd_valid is low.

Reset:
- cnt, all E/T/D, all act_E/act_T: 0.
- pwm, dir, d_out, rd_valid, frame_start: 0.
- Reset asserted mid-frame: the next edge applies reset values; after release, counting restarts at cnt = 0.

## Timing
- pwm and frame_start are registered from the current cnt value and appear one cycle after it.
- frame_start is high in the cycle where pwm reflects cnt == 0.
- Pulse length per frame is exactly min(act_T, PERIOD_CYCLES) clk cycles, with a rising edge coincident with frame_start.
- Write to T at any cycle of frame k (except the load edge) → new width visible from the start of frame k+1.
- Readback latency: 1 cycle, fully pipelined; back-to-back rd_req is allowed each cycle.
- Write-to-dir latency: 1 cycle.

## Configuration
- Macro: SERVO_FRAME_CNT_EN.
- Defined:
  - A 16-bit frame counter increments on every frame_start, wrapping 0xFFFF → 0; reset value 0.
  - rd_sel = 24 returns {16'h0, frame_cnt}.
- Undefined:
  - No counter logic is built.
  - rd_sel = 24 returns 0.

## Test plan
Run with PERIOD_CYCLES = 100.
1. Reset: hold rst = 0 for 3 cycles with writes active → all outputs 0; readback of every index returns 0 after release.
2. Basic PWM: write T0 = 25 and E0 = 1 mid-frame → pwm[0] unchanged for the rest of the frame; next frame it is high exactly 25 cycles starting with frame_start, low for 75; other channels stay 0.
3. Boundaries:
   - T1 = 0 with E1 = 1 → pwm[1] always low.
   - T2 = 100 and T2 = 0xFFFFFFFF → pwm[2] constant high.
   - E3 = 3 with T3 = 10 → pwm[3] low for 10 cycles, high for 90.
4. Load-edge write: write T0 = 50 on the exact load cycle → the next frame still uses the old width; the frame after uses 50.
5. Readback:
   - Write D5 = 2'b11 → dir[5] = 1 one cycle later.
   - rd_req with rd_sel = 17 → d_out = 3 with rd_valid one cycle later.
   - Read/write collision on index 4 → the old value is returned.
   - rd_sel = 30 → returns 0.
6. SERVO_FRAME_CNT_EN: after 5 frames, rd_sel = 24 returns 5; with the macro undefined it returns 0.
